// File: rtl/if_fetch_ctrl_pkg.sv
// Shared pipeline definitions: reset/stop levels, bus widths and fetch FSM encodings.
package if_fetch_ctrl_pkg;

  localparam logic RST_ENABLE = 1'b1;
  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    FETCH_IDLE       = 2'd0,
    FETCH_BUSY       = 2'd1,
    FETCH_WAIT_STALL = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding bus request, branch/flush redirect,
// and delivery of instruction/PC pairs to the IF/ID boundary.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int               ADDR_W   = INST_ADDR_W,
  parameter int               DATA_W   = INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              ibus_req,
  output logic [ADDR_W-1:0] ibus_addr,
  input  logic              ibus_ack,
  input  logic [DATA_W-1:0] ibus_rdata,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o,
  output logic              stallreq_from_if
);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, pc_val, br_tgt, fl_tgt;
  logic [DATA_W-1:0] inst_buf, deliver_data;
  logic              br_pend, fl_pend, stall_if, deliver, pc_load;

  // The PC stage stall bit is redundant: the PC only moves on delivery.
  logic unused_stall;
  assign unused_stall = ^{stall[5:2], stall[0]};

  assign stall_if = (stall[1] == STOP);
  assign pc_nxt   = br_pend ? br_tgt : pc + ADDR_W'(4);

  assign stallreq_from_if = (state == FETCH_IDLE) || ((state == FETCH_BUSY) && !ibus_ack);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) state <= FETCH_IDLE;
    else                   state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    deliver      = 1'b0;
    deliver_data = inst_buf;
    pc_load      = 1'b0;
    pc_val       = pc_nxt;
    case (state)
      FETCH_IDLE: begin
        if (flush) begin
          pc_load = 1'b1;
          pc_val  = new_pc;
        end else begin
          state_nxt = FETCH_BUSY;
        end
      end
      FETCH_BUSY: begin
        if (ibus_ack) begin
          if (flush || fl_pend) begin
            state_nxt = FETCH_IDLE;
            pc_load   = 1'b1;
            pc_val    = flush ? new_pc : fl_tgt;
          end else if (stall_if) begin
            state_nxt = FETCH_WAIT_STALL;
          end else begin
            state_nxt    = FETCH_IDLE;
            deliver      = 1'b1;
            deliver_data = ibus_rdata;
            pc_load      = 1'b1;
          end
        end
      end
      FETCH_WAIT_STALL: begin
        if (flush) begin
          state_nxt = FETCH_IDLE;
          pc_load   = 1'b1;
          pc_val    = new_pc;
        end else if (!stall_if) begin
          state_nxt = FETCH_IDLE;
          deliver   = 1'b1;
          pc_load   = 1'b1;
        end
      end
      default: state_nxt = FETCH_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      pc           <= RESET_PC;
      br_pend      <= 1'b0;
      fl_pend      <= 1'b0;
      ibus_req     <= 1'b0;
      ibus_addr    <= '0;
      inst_o       <= '0;
      inst_pc_o    <= '0;
      inst_valid_o <= 1'b0;
    end else begin
      if (state == FETCH_IDLE && !flush) begin
        ibus_req  <= 1'b1;
        ibus_addr <= pc;
      end else if (state == FETCH_BUSY && ibus_ack) begin
        ibus_req <= 1'b0;
      end

      if (pc_load) begin
        pc      <= pc_val;
        br_pend <= 1'b0;
      end

      if (state == FETCH_BUSY) begin
        if (ibus_ack)   fl_pend <= 1'b0;
        else if (flush) fl_pend <= 1'b1;
      end

      if (deliver) begin
        inst_o       <= deliver_data;
        inst_pc_o    <= pc;
        inst_valid_o <= 1'b1;
      end else if (flush || !stall_if) begin
        inst_o       <= ZERO_WORD[DATA_W-1:0];
        inst_valid_o <= 1'b0;
      end

      // A redirect arriving together with a PC update must not be lost.
      if (branch_flag) br_pend <= 1'b1;
    end
  end

  // NOTE: pure data holding registers are not reset; their pending/valid flags guard every use.
  always_ff @(posedge clk) begin
    if (branch_flag) br_tgt <= branch_target;
    if (state == FETCH_BUSY && !ibus_ack && flush) fl_tgt <= new_pc;
    if (state == FETCH_BUSY && ibus_ack && !flush && !fl_pend && stall_if) inst_buf <= ibus_rdata;
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios plus random traffic, scored against a
// transaction-level model of the fetch rules.
module tb_if_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush, branch_flag, ibus_ack;
  logic [31:0] new_pc, branch_target, ibus_rdata;
  logic        ibus_req, inst_valid_o, stallreq_from_if;
  logic [31:0] ibus_addr, inst_o, inst_pc_o;

  if_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_ack(ibus_ack), .ibus_rdata(ibus_rdata),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o),
    .stallreq_from_if(stallreq_from_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];

  // Transaction-level view: a request is either outstanding, or a fetched word is parked
  // waiting for IF to unstall, or nothing is in flight.
  logic        m_busy, m_hold, m_brp, m_flp, m_req, m_valid;
  logic [31:0] m_pc, m_brt, m_flt, m_word, m_addr, m_inst, m_ipc;

  task automatic model_step(input logic r, s1, fl, input logic [31:0] npc,
                            input logic br, input logic [31:0] bt,
                            input logic ack, input logic [31:0] rd);
    logic        dlv = 1'b0;
    logic [31:0] w   = '0;
    logic [31:0] seq = m_brp ? m_brt : m_pc + 32'd4;
    if (r) begin
      m_busy = 0; m_hold = 0; m_brp = 0; m_flp = 0; m_pc = RESET_PC;
      m_req = 0; m_addr = 0; m_inst = 0; m_ipc = 0; m_valid = 0;
      return;
    end
    if (m_busy) begin
      if (!ack) begin
        if (fl) begin m_flp = 1; m_flt = npc; end
      end else begin
        m_busy = 0;
        m_req  = 0;
        if (fl || m_flp) begin
          m_pc = fl ? npc : m_flt; m_flp = 0; m_brp = 0;
        end else if (s1) begin
          m_hold = 1; m_word = rd;
        end else begin
          dlv = 1; w = rd;
        end
      end
    end else if (m_hold) begin
      if (fl) begin m_hold = 0; m_pc = npc; m_brp = 0; end
      else if (!s1) begin m_hold = 0; dlv = 1; w = m_word; end
    end else if (fl) begin
      m_pc = npc; m_brp = 0;
    end else begin
      m_busy = 1; m_req = 1; m_addr = m_pc;
    end
    if (dlv) begin
      m_inst = w; m_ipc = m_pc; m_valid = 1; m_pc = seq; m_brp = 0;
    end else if (fl || !s1) begin
      m_inst = 0; m_valid = 0;
    end
    if (br) begin m_brp = 1; m_brt = bt; end
  endtask

  task automatic cycle(input logic r, s1, fl, input logic [31:0] npc,
                       input logic br, input logic [31:0] bt,
                       input logic ack, input logic [31:0] rd);
    exp_t e;
    logic exp_sr;
    @(negedge clk);
    rst = r; stall = {4'($urandom), s1, 1'($urandom)}; flush = fl; new_pc = npc;
    branch_flag = br; branch_target = bt; ibus_ack = ack; ibus_rdata = rd;
    exp_sr = m_hold ? 1'b0 : (m_busy ? !ack : 1'b1);
    #1;
    check("stallreq_from_if", 32'(stallreq_from_if), 32'(exp_sr));
    model_step(r, s1, fl, npc, br, bt, ack, rd);
    e.req = m_req; e.addr = m_addr; e.inst = m_inst; e.pc = m_ipc; e.valid = m_valid;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    cycle(0, 0, 0, '0, 0, '0, 0, '0);
  endtask

  task automatic ack_with(input logic s1, input logic [31:0] rd);
    cycle(0, s1, 0, '0, 0, '0, 1, rd);
  endtask

  // Monitor: compares each registered-output snapshot one step after the edge it describes.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ibus_req",     32'(ibus_req),     32'(e.req));
        check("ibus_addr",    ibus_addr,         e.addr);
        check("inst_o",       inst_o,            e.inst);
        check("inst_pc_o",    inst_pc_o,         e.pc);
        check("inst_valid_o", 32'(inst_valid_o), 32'(e.valid));
      end
    end
  end

  initial begin
    rst = 1; stall = '0; flush = 0; new_pc = '0; branch_flag = 0;
    branch_target = '0; ibus_ack = 0; ibus_rdata = '0;
    m_busy = 0; m_hold = 0; m_brp = 0; m_flp = 0; m_pc = RESET_PC;
    m_brt = '0; m_flt = '0; m_word = '0; m_req = 0; m_addr = '0;
    m_inst = '0; m_ipc = '0; m_valid = 0;

    cycle(1, 0, 0, '0, 0, '0, 0, '0);
    cycle(1, 0, 0, '0, 0, '0, 0, '0);

    // Two plain fetches, ack two cycles after each request.
    idle(); idle(); ack_with(0, 32'h2401_0001);
    idle(); idle(); ack_with(0, 32'h2402_0002);

    // Branch redirect while fetching 0x8.
    idle(); cycle(0, 0, 0, '0, 1, 32'h100, 0, '0); ack_with(0, 32'h1111_0008);

    // IF stalled for three cycles, ack in the first.
    idle(); idle();
    ack_with(1, 32'hABCD_0100);
    cycle(0, 1, 0, '0, 0, '0, 0, '0);
    cycle(0, 1, 0, '0, 0, '0, 0, '0);
    idle(); idle(); idle(); ack_with(0, 32'h0000_0104);

    // Flush mid-BUSY, then flush in the ack cycle.
    idle(); cycle(0, 0, 1, 32'h180, 0, '0, 0, '0); idle(); ack_with(0, 32'hDEAD_0001);
    idle(); idle(); cycle(0, 0, 1, 32'h180, 0, '0, 1, 32'hDEAD_0002);
    idle(); ack_with(0, 32'h0000_0180);

    // Reset mid-BUSY with a stray ack right after release.
    idle(); cycle(1, 0, 0, '0, 0, '0, 0, '0);
    cycle(0, 0, 0, '0, 0, '0, 1, 32'hBAD0_BAD0);
    idle(); ack_with(0, 32'h0000_0000);

    // PC wrap at the top of the address space.
    cycle(0, 0, 1, 32'hFFFF_FFFC, 0, '0, 0, '0);
    idle(); ack_with(0, 32'h7777_FFFC);
    idle(); ack_with(0, 32'h8888_0000);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic r, s1, fl, br, ack;
      r   = ($urandom_range(0, 249) == 0);
      s1  = ($urandom_range(0, 2) == 0);
      fl  = ($urandom_range(0, 11) == 0);
      br  = ($urandom_range(0, 7) == 0);
      ack = m_busy && ($urandom_range(0, 2) == 0);
      cycle(r, s1, fl, {$urandom} & 32'hFFFF_FFFC, br, {$urandom} & 32'hFFFF_FFFC, ack, $urandom);
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 5-stage pipeline. It owns the fetch PC and issues one request at a time on the instruction bus.
- It honours the pipeline stall vector, branch redirects and exception flushes, and delivers instruction/PC pairs to the IF/ID boundary.
- It asserts a stall request to the pipeline controller while a fetch is outstanding.

Parameters:
ADDR_W, 32, instruction address width
DATA_W, 32, instruction word width
RESET_PC, 32'h00000000, PC after reset

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high (1 = reset)
stall  in  6  pipeline stall vector; bit0 = PC, bit1 = IF, 1 = stop
flush  in  1  exception flush, one cycle
new_pc  in  ADDR_W  flush target, valid with flush
branch_flag  in  1  taken-branch redirect from ID, one cycle
branch_target  in  ADDR_W  redirect target, valid with branch_flag
ibus_req  out  1  bus request, held until ack
ibus_addr  out  ADDR_W  fetch address, stable while ibus_req is high
ibus_ack  in  1  one-cycle completion strobe
ibus_rdata  in  DATA_W  instruction, valid with ibus_ack
inst_o  out  DATA_W  delivered instruction
inst_pc_o  out  ADDR_W  PC of inst_o
inst_valid_o  out  1  inst_o holds a real instruction
stallreq_from_if  out  1  combinational stall request to the pipeline controller

Behaviour:
- Reset values: state=IDLE, pc=RESET_PC, ibus_req=0, ibus_addr=0, inst_o=0, inst_pc_o=0, inst_valid_o=0, br_pend=0, fl_pend=0.
- Reset has priority over every other input, including mid-BUSY. Any bus ack arriving after reset is ignored.
- Next PC (nxt): br_pend ? br_tgt : pc+4. The +4 wraps modulo 2^ADDR_W.
- Branch capture: branch_flag=1 sets br_pend=1 and br_tgt=branch_target in any state.
  - br_pend is cleared whenever pc is updated.
  - A later branch_flag overwrites an earlier one.
- IDLE state:
  - flush=1: pc<=new_pc, br_pend<=0, stay IDLE.
  - Otherwise: ibus_req<=1, ibus_addr<=pc, go to BUSY.
- BUSY state, ack=0:
  - Hold ibus_req and ibus_addr.
  - flush=1: fl_pend<=1, fl_tgt<=new_pc.
- BUSY state, ack=1:
  - Always: ibus_req<=0.
  - flush=1 or fl_pend=1: discard the data. pc<=(flush ? new_pc : fl_tgt); clear fl_pend and br_pend; go to IDLE. A flush in the ack cycle wins over fl_tgt.
  - Else if stall[1]=1: buf<=ibus_rdata, go to WAIT_STALL.
  - Else deliver: inst_o<=ibus_rdata, inst_pc_o<=pc, inst_valid_o<=1, pc<=nxt, go to IDLE.
- WAIT_STALL state:
  - flush=1: discard buf, pc<=new_pc, clear br_pend, go to IDLE.
  - Else if stall[1]=0: deliver buf (same as the BUSY deliver case), pc<=nxt, go to IDLE.
- Output register update, for cycles with no delivery:
  - stall[1]=1: hold inst_o, inst_pc_o, inst_valid_o.
  - stall[1]=0: inst_o<=0 (NOP bubble), inst_valid_o<=0.
  - flush=1: always inst_o<=0 and inst_valid_o<=0, regardless of stall.
- stallreq_from_if = (state==IDLE) | (state==BUSY & ~ibus_ack). It is low in WAIT_STALL and in the ack cycle, which avoids a deadlock loop with stall[1].
- Throughput: at best one instruction per (2 + bus latency) cycles; no prefetch.
- stall[0] is not needed to gate the PC: the PC only advances on delivery, which is already gated by stall[1].
- Only one request is ever outstanding. ibus_addr must not change while ibus_req=1.

Decomposition:
- Shared defines header (same one used by the pipeline): RstEnable, Stop/NoStop, ZeroWord, InstAddrBus/InstBus widths, and the state encodings FETCH_IDLE, FETCH_BUSY, FETCH_WAIT_STALL.
- No sub-module: a single FSM plus datapath registers. The next-PC mux may be written inline.

Test Plan:
- Reset, then ack 2 cycles after each request with rdata=0x24010001, 0x24020002 -> ibus_addr 0x0 then 0x4; inst_pc_o 0x0/0x4 with inst_valid_o=1; stallreq_from_if high during IDLE and non-ack BUSY cycles.
- stall[1]=1 held for 3 cycles, ack arriving in the first of them -> WAIT_STALL; inst_o unchanged while stalled; buffered word delivered the cycle after stall[1] drops; ibus_addr next = pc+4.
- branch_flag=1, branch_target=0x100 while BUSY fetching 0x8 -> 0x8 delivered, next ibus_addr=0x100.
- flush=1, new_pc=0x180 mid-BUSY, ack 2 cycles later -> data discarded, inst_valid_o=0, next ibus_addr=0x180. Repeat with flush in the ack cycle -> same result.
- rst=1 asserted mid-BUSY, ack arriving after release -> all outputs at reset values, first ibus_addr=RESET_PC, stray ack ignored.
- pc=0xFFFFFFFC delivered -> next ibus_addr=0x00000000 (wrap).
